// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//
// Multi-cycle adder/subtractor. The operands are captured in one cycle, then
// added CHUNK bits per clock, least-significant chunk first, with the carry
// rippling through a single carry register. The result is held until the
// consumer accepts it.
//
// Latency: out_valid rises exactly NCHUNK = WIDTH/CHUNK rising edges after the
// edge that accepted the operands.
//
// Parameters
//   WIDTH      operand/result width in bits (default 32)
//   CHUNK      bits added per clock; WIDTH must be a multiple of CHUNK
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented            in_ready   ready to accept (IDLE)
//   a, b       operands                      cin        carry-in (add only)
//   sub        0 = a+b+cin, 1 = a-b
//   out_valid  result available (DONE)       out_ready  consumer takes result
//   sum        result (mod 2^WIDTH)          cout       raw carry out of MSB
//                                                       (1 on subtract = no borrow)
//   ovf        two's-complement overflow (only with SEQ_ADDER_OVF_EN)
//
// Configuration macro
//   SEQ_ADDER_OVF_EN  when defined, adds the ovf output and its logic.
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_a;        // captured a
    logic [WIDTH-1:0]   r_b;        // effective operand: b or ~b
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK:0]     w_chunk_add;
    logic               w_accept;

    assign w_accept = (r_state == IDLE) && in_valid;

    // Select the chunk addressed by r_idx from both registered operands.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_chunk = r_a[k*CHUNK +: CHUNK];
                w_b_chunk = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    assign w_chunk_add = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

    // Operand capture. These registers are only ever read in RUN, after an
    // accept has loaded them, so they carry no reset.
    // NOTE: pure datapath registers whose contents are always written before
    // use are left out of reset; resetting them buys nothing and costs routing.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= sub ? ~b : b;
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Overflow of a + b_eff: operand signs agree but the result sign differs.
    // On the last chunk, bit CHUNK-1 of the chunk sum is the result MSB.
    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                   (w_chunk_add[CHUNK-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && r_idx == LAST_IDX) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

    // Control FSM and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1; the +1 rides in the carry.
                        r_carry    <= sub ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                    end
                end

                RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_sum[k*CHUNK +: CHUNK] <= w_chunk_add[CHUNK-1:0];
                        end
                    end
                    r_carry <= w_chunk_add[CHUNK];
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_chunk_add[CHUNK];
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    // in_valid is ignored here; a new accept can only happen
                    // on the edge after the return to IDLE.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_adder
//
// Self-checking bench for seq_chunk_adder. A transaction-level model tracks
// whether an operation is outstanding, the cycle it was accepted on and the
// arithmetic result; a compare process checks the DUT against it on every
// falling edge. Directed cases pin literal results, latency, backpressure and
// reset; a randomized phase then exercises the handshakes freely. Two extra
// instances (CHUNK=4 and CHUNK=32) cover the parameter sweep.
// Define SEQ_ADDER_OVF_EN to also check the ovf output.
// -----------------------------------------------------------------------------
module tb_seq_chunk_adder;

    localparam int W   = 32;
    localparam int NCH = 4;     // main instance: WIDTH=32, CHUNK=8
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -MAXS - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, out_valid, out_ready, cin, sub, cout;
    logic [W-1:0] a, b, sum;

    // Sweep instances share operands but have their own handshake.
    logic         sv_valid, sv_ready;
    logic         in_ready4, out_valid4, cout4;
    logic         in_ready32, out_valid32, cout32;
    logic [W-1:0] sum4, sum32;
`ifdef SEQ_ADDER_OVF_EN
    logic         ovf, ovf4, ovf32;
`endif

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv_valid), .in_ready(in_ready4),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid4),
        .out_ready(sv_ready), .sum(sum4), .cout(cout4)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv_valid), .in_ready(in_ready32),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid32),
        .out_ready(sv_ready), .sum(sum32), .cout(cout32)
`ifdef SEQ_ADDER_OVF_EN
        , .ovf(ovf32)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, sum}.
    function automatic logic [33:0] model_op(input logic [31:0] x, input logic [31:0] y,
                                             input logic c, input logic s);
        longint      sx, sy, res;
        logic [31:0] r;
        logic [32:0] wide;
        logic        co, ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r   = x - y;
            co  = (x >= y);             // carry out of a + ~b + 1 means no borrow
            res = sx - sy;
        end else begin
            wide = {1'b0, x} + {1'b0, y} + {32'b0, c};
            r    = wide[31:0];
            co   = wide[32];
            res  = sx + sy + longint'(c);
        end
        ov = (res > MAXS) || (res < MINS);
        return {ov, co, r};
    endfunction

    // ---------------- transaction model ----------------
    bit          m_pending = 1'b0;
    int          cyc = 0;
    int          m_acc = 0;
    logic [33:0] m_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending = 1'b0;
            cyc       = 0;
        end else begin
            cyc++;
            if (!m_pending) begin
                if (in_valid) begin
                    m_pending = 1'b1;
                    m_acc     = cyc;
                    m_exp     = model_op(a, b, cin, sub);
                end
            end else if ((cyc - 1 - m_acc) >= NCH && out_ready) begin
                m_pending = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit ev;
        if (!rst_n) begin
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_sum", 64'(sum), 64'd0);
            check("rst_cout", 64'(cout), 64'd0);
`ifdef SEQ_ADDER_OVF_EN
            check("rst_ovf", 64'(ovf), 64'd0);
`endif
        end else begin
            ev = m_pending && ((cyc - m_acc) >= NCH);
            check("cmp_in_ready", 64'(in_ready), 64'(!m_pending));
            check("cmp_out_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                check("cmp_sum", 64'(sum), 64'(m_exp[31:0]));
                check("cmp_cout", 64'(cout), 64'(m_exp[32]));
`ifdef SEQ_ADDER_OVF_EN
                check("cmp_ovf", 64'(ovf), 64'(m_exp[33]));
`endif
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_idle(input string name);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_idle_timeout"}, 64'(guard < 100), 64'd1);
    endtask

    // Wait (bounded) for out_valid; returns edges counted after the accept.
    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_valid_timeout"}, 64'(lat < 50), 64'd1);
    endtask

    task automatic do_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tc, input logic ts, input logic [31:0] es,
                         input logic ec, input logic eo);
        int lat;
        wait_idle(name);
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);                 // accepting edge has passed
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        wait_valid(name, lat);
        check({name, "_latency"}, 64'(lat), 64'(NCH));
        check({name, "_sum"}, 64'(sum), 64'(es));
        check({name, "_cout"}, 64'(cout), 64'(ec));
`ifdef SEQ_ADDER_OVF_EN
        check({name, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected X overflow expectation in %s", name);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int lat, l4, l32;
        logic [31:0] held;

        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        sv_valid = 1'b0; sv_ready = 1'b1;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pin the reference model with hand-computed results.
        check("model_add_wrap", 64'(model_op(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0)), 64'h1_0000_0000);
        check("model_sub_borrow", 64'(model_op(32'h5, 32'h7, 1'b0, 1'b1)), 64'h0_FFFF_FFFE);
        check("model_ovf", 64'(model_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0)), 64'h2_8000_0000);

        // Parameter sweep: CHUNK=4 (8 edges) and CHUNK=32 (1 edge).
        a = 32'h12345678; b = 32'h9ABCDEF0; cin = 1'b0; sub = 1'b0; sv_valid = 1'b1;
        @(negedge clk);
        sv_valid = 1'b0;
        l4 = -1; l32 = -1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (out_valid4 && l4 < 0) begin
                l4 = t;
                check("sweep4_sum", 64'(sum4), 64'h00000000ACF13568);
                check("sweep4_cout", 64'(cout4), 64'd0);
            end
            if (out_valid32 && l32 < 0) begin
                l32 = t;
                check("sweep32_sum", 64'(sum32), 64'h00000000ACF13568);
                check("sweep32_cout", 64'(cout32), 64'd0);
            end
        end
        check("sweep4_latency", 64'(l4), 64'd8);
        check("sweep32_latency", 64'(l32), 64'd1);
        check("sweep4_back_idle", 64'(in_ready4), 64'd1);
        check("sweep32_back_idle", 64'(in_ready32), 64'd1);

        // Directed arithmetic cases with literal expectations.
        do_op("add_wrap", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
        do_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("sub_noborrow", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
        do_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        do_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // Backpressure: result held for 10 cycles while new operands knock.
        wait_idle("bp");
        a = 32'h3; b = 32'h4; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("bp", lat);
        held = sum;
        check("bp_first_sum", 64'(held), 64'd7);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; out_ready = 1'b0;
            @(negedge clk);
            check("bp_sum_stable", 64'(sum), 64'(held));
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid_high", 64'(out_valid), 64'd1);
        end
        a = 32'h11; b = 32'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);                 // DONE -> IDLE, in_valid ignored
        out_ready = 1'b0;
        check("bp_idle_in_ready", 64'(in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);                 // accept on the following edge
        in_valid = 1'b0;
        check("bp_accepted", 64'(in_ready), 64'd0);
        wait_valid("bp2", lat);
        check("bp2_latency", 64'(lat), 64'(NCH));
        check("bp2_sum", 64'(sum), 64'h33);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN aborts the operation.
        wait_idle("rst");
        a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);                 // at least one chunk written
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_sum", 64'(sum), 64'd0);
        check("midrun_rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_result", 64'(out_valid), 64'd0);
        do_op("post_rst_add", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       a = 32'hFFFFFFFF;
                1:       a = 32'h7FFFFFFF;
                2:       a = 32'h80000000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h00000000;
                1:       b = 32'h00000001;
                2:       b = a;
                default: b = $urandom;
            endcase
            cin = 1'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
